// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared types and constants for the radix-2 Booth multiplier.
//                Defines the default operand width, the sequencer state type,
//                and the encoding of the two-bit Booth selector {Q[0], Q-1}.
//  Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    // Default operand width; the product is twice this wide.
    localparam int BOOTH_N = 8;

    // Sequencer states. LOAD is the power-up state, left by the first reset.
    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    // Booth selector values formed as {Qreg[0], Qm1}.
    localparam logic [1:0] c_BOOTH_NOP0 = 2'b00;  // inside a run of zeros
    localparam logic [1:0] c_BOOTH_ADD  = 2'b01;  // end of a run of ones
    localparam logic [1:0] c_BOOTH_SUB  = 2'b10;  // start of a run of ones
    localparam logic [1:0] c_BOOTH_NOP1 = 2'b11;  // inside a run of ones

endpackage : booth_pkg
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ============================================================================
//  Module      : booth_step
//  Description : One combinational radix-2 Booth iteration. Adds, subtracts or
//                skips the multiplicand according to {Q[0], Q-1}, then shifts
//                {A, Q, Q-1} arithmetically right by one bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_step
    import booth_pkg::*;
#(
    parameter int N = BOOTH_N
)
(
    input  logic [N:0]   i_a,
    input  logic [N-1:0] i_q,
    input  logic         i_qm1,
    input  logic [N:0]   i_mreg,
    output logic [N:0]   o_a,
    output logic [N-1:0] o_q,
    output logic         o_qm1
);

    // One extra guard bit keeps the add/sub exact before the shift; the
    // shifted result always fits back into N+1 bits.
    logic [N+1:0] w_a_ext;
    logic [N+1:0] w_m_ext;
    logic [N+1:0] w_sum;

    assign w_a_ext = {i_a[N], i_a};
    assign w_m_ext = {i_mreg[N], i_mreg};

    // Select add, subtract or pass-through from the Booth selector.
    always_comb begin
        w_sum = w_a_ext;
        case ({i_q[0], i_qm1})
            c_BOOTH_ADD:  w_sum = w_a_ext + w_m_ext;
            c_BOOTH_SUB:  w_sum = w_a_ext - w_m_ext;
            c_BOOTH_NOP0: w_sum = w_a_ext;
            c_BOOTH_NOP1: w_sum = w_a_ext;
            default:      w_sum = w_a_ext;
        endcase
    end

    // Arithmetic right shift of {A, Q, Q-1}: the sign of the sum fills A's MSB.
    assign o_a   = w_sum[N+1:1];
    assign o_q   = {w_sum[0], i_q[N-1:1]};
    assign o_qm1 = i_q[0];

endmodule : booth_step
`default_nettype wire

// File: rtl/booth_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : booth_multiplier
//  Description : Sequential signed radix-2 Booth multiplier, one step per
//                clock. Operands are captured while rst is high; the 2N-bit
//                product is registered N cycles after rst is released.
//                Optional macro BOOTH_LIVE_PRODUCT_EN: when defined, P follows
//                the running partial product on every RUN cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_multiplier
    import booth_pkg::*;
#(
    parameter int N = BOOTH_N
)
(
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   m,
    input  logic [N-1:0]   q,
    output logic [2*N-1:0] P
);

    localparam int             CW          = $clog2(N + 1);
    localparam logic [CW-1:0]  c_LAST_STEP = CW'(N - 1);
    localparam logic [CW-1:0]  c_CNT_ONE   = CW'(1);

    booth_state_t   r_state;
    booth_state_t   w_state_nxt;

    logic [N:0]     r_a;
    logic [N:0]     r_mreg;
    logic [N-1:0]   r_q;
    logic           r_qm1;
    logic [CW-1:0]  r_cnt;
    logic [2*N-1:0] r_p;

    logic [N:0]     w_a_step;
    logic [N-1:0]   w_q_step;
    logic           w_qm1_step;
    logic           w_step_en;
    logic           w_last_step;

    // Booth iteration datapath applied to the current register contents.
    booth_step #(
        .N      (N)
    ) u_step (
        .i_a    (r_a),
        .i_q    (r_q),
        .i_qm1  (r_qm1),
        .i_mreg (r_mreg),
        .o_a    (w_a_step),
        .o_q    (w_q_step),
        .o_qm1  (w_qm1_step)
    );

    // State register: reset always (re)starts a multiplication.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: RUN ends on the Nth step, LOAD and DONE hold.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD:    w_state_nxt = LOAD;
            RUN:     w_state_nxt = w_last_step ? DONE : RUN;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = LOAD;
        endcase
    end

    // Output decode: step enable and final-step flag.
    always_comb begin
        w_step_en   = (r_state == RUN);
        w_last_step = w_step_en && (r_cnt == c_LAST_STEP);
    end

    // Datapath registers: capture operands on reset, then one step per RUN edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_mreg <= {m[N-1], m};
            r_q    <= q;
            r_qm1  <= 1'b0;
            r_cnt  <= '0;
            r_p    <= '0;
        end else if (w_step_en) begin
            r_a    <= w_a_step;
            r_q    <= w_q_step;
            r_qm1  <= w_qm1_step;
            r_cnt  <= r_cnt + c_CNT_ONE;
`ifdef BOOTH_LIVE_PRODUCT_EN
            // Expose the partial product each step; the last step yields the result.
            r_p    <= {w_a_step[N-1:0], w_q_step};
`else
            if (w_last_step) begin
                r_p <= {w_a_step[N-1:0], w_q_step};
            end
`endif
        end
    end

    assign P = r_p;

endmodule : booth_multiplier
`default_nettype wire

// File: tb/tb_booth_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_multiplier
//  Description : Directed self-checking bench for booth_multiplier (N = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_multiplier;

    localparam int N = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   m;
    logic [N-1:0]   q;
    logic [2*N-1:0] P;

    int n_checks = 0;
    int n_fail   = 0;

    booth_multiplier #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .m   (m),
        .q   (q),
        .P   (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive-only: hold rst for one rising edge with the given operands.
    // Returns at the falling edge right after that reset edge.
    task automatic start_op(input logic [N-1:0] mm, input logic [N-1:0] qq);
        @(negedge clk);
        m   = mm;
        q   = qq;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        start_op(8'h7D, 8'h26);
        n_checks++;
        if (P !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_clear: P=%h expected %h", P, 16'h0000);
        end
    endtask

    // Continues the 125*38 operation launched by test_reset.
    task automatic test_basic();
        logic seen_live;
        seen_live = 1'b0;
        for (int j = 1; j <= N; j++) begin
            @(negedge clk);
            if (j < N) begin
`ifdef BOOTH_LIVE_PRODUCT_EN
                if (P !== 16'h0000) seen_live = 1'b1;
`else
                n_checks++;
                if (P !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL basic_early_c%0d: P=%h expected %h", j, P, 16'h0000);
                end
`endif
            end else begin
                n_checks++;
                if (P !== 16'h128E) begin
                    n_fail++;
                    $display("FAIL basic_125x38: P=%h expected %h", P, 16'h128E);
                end
            end
        end
`ifdef BOOTH_LIVE_PRODUCT_EN
        n_checks++;
        if (seen_live !== 1'b1) begin
            n_fail++;
            $display("FAIL live_visible: seen=%b expected %b", seen_live, 1'b1);
        end
`endif
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            n_checks++;
            if (P !== 16'h128E) begin
                n_fail++;
                $display("FAIL basic_stable_%0d: P=%h expected %h", j, P, 16'h128E);
            end
        end
    endtask

    task automatic test_negative();
        start_op(8'hA1, 8'h26);
        n_checks++;
        if (P !== 16'h0000) begin
            n_fail++;
            $display("FAIL neg_reset_cycle: P=%h expected %h", P, 16'h0000);
        end
        repeat (N) @(negedge clk);
        n_checks++;
        if (P !== 16'hF1E6) begin
            n_fail++;
            $display("FAIL neg_m95x38: P=%h expected %h", P, 16'hF1E6);
        end
    endtask

    task automatic test_corners();
        logic [N-1:0]   tm [4];
        logic [N-1:0]   tq [4];
        logic [2*N-1:0] tp [4];
        tm[0] = 8'h80; tq[0] = 8'h80; tp[0] = 16'h4000;
        tm[1] = 8'h7F; tq[1] = 8'h80; tp[1] = 16'hC080;
        tm[2] = 8'hFF; tq[2] = 8'hFF; tp[2] = 16'h0001;
        tm[3] = 8'h00; tq[3] = 8'h55; tp[3] = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            start_op(tm[i], tq[i]);
            repeat (N) @(negedge clk);
            n_checks++;
            if (P !== tp[i]) begin
                n_fail++;
                $display("FAIL corner_%0d m=%h q=%h: P=%h expected %h",
                         i, tm[i], tq[i], P, tp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        start_op(8'h7D, 8'h26);
        // Steps 1..3 run; the edge that would perform step 4 sees rst instead.
        repeat (3) @(negedge clk);
        m   = 8'hA1;
        q   = 8'h26;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int j = 1; j <= 2 * N; j++) begin
            @(negedge clk);
            if (j == N) begin
                n_checks++;
                if (P !== 16'hF1E6) begin
                    n_fail++;
                    $display("FAIL mid_restart: P=%h expected %h", P, 16'hF1E6);
                end
            end else begin
                n_checks++;
                if (P === 16'h128E) begin
                    n_fail++;
                    $display("FAIL mid_stale_c%0d: P=%h expected not %h", j, P, 16'h128E);
                end
            end
        end
    endtask

    task automatic test_hold();
        // Previous test left P = 0xF1E6 in DONE.
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            m = N'($urandom);
            q = N'($urandom);
            n_checks++;
            if (P !== 16'hF1E6) begin
                n_fail++;
                $display("FAIL hold_%0d: P=%h expected %h", j, P, 16'hF1E6);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        m   = '0;
        q   = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_negative();
        test_corners();
        test_reset_mid();
        test_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_booth_multiplier
`default_nettype wire

// File: doc/booth_multiplier.md
Name: booth_multiplier

Overview:
- Sequential signed radix-2 Booth multiplier. Multiplies two N-bit two's-complement operands into a 2N-bit signed product, one Booth step per clock.
- Used as a standalone arithmetic block in the multipliers set. Operands are captured while reset is held; the product appears N cycles after reset release.

Parameters:
- N, 8, operand width in bits (N >= 2). Product width is 2N.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset. While high, clears state and captures the operands.
- m  input  N  multiplicand, signed two's complement. Sampled only on edges where rst=1.
- q  input  N  multiplier, signed two's complement. Sampled only on edges where rst=1.
- P  output  2N  signed product, registered.

Behaviour:
- Internal registers:
  - A: N+1 bits, accumulator, sign-extended so that m = -2^(N-1) cannot overflow.
  - Mreg: N+1 bits, sign-extended m.
  - Qreg: N bits.
  - Qm1: 1 bit.
  - cnt: ceil(log2(N+1)) bits.
  - state: LOAD / RUN / DONE.
- Rising edge with rst=1, regardless of current state:
  - A=0, Mreg=sext(m), Qreg=q, Qm1=0, cnt=0, P=0, state=RUN.
  - Reset mid-operation aborts and restarts with the new operands.
- RUN, each edge with rst=0, one Booth step:
  - {Qreg[0],Qm1}=01: A = A + Mreg.
  - {Qreg[0],Qm1}=10: A = A - Mreg.
  - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Qreg,Qm1} by one; the MSB of A is replicated.
  - cnt increments.
- Completion: on the edge performing step N (cnt == N-1):
  - P is loaded with the low 2N bits of {A_after_shift, Qreg_after_shift}.
  - state goes to DONE.
- DONE: all registers hold. P stays stable until the next rst=1 edge.
- Latency: with rst high at edge k and low from edge k+1 onward, P is valid after edge k+N and remains valid indefinitely.
- LOAD is the power-up / pre-reset state: no steps are performed and P holds. The first rst=1 edge leaves it.
- rst and a completing step on the same edge: reset wins.
- All products of N-bit signed operands are exact, including (-2^(N-1))*(-2^(N-1)) = 2^(2N-2).
- No combinational path from inputs to P.

Optional Feature:
- Macro BOOTH_LIVE_PRODUCT_EN.
- Defined:
  - P is updated every RUN edge with the low 2N bits of the current {A,Qreg}, so partial products are visible.
  - The final value and timing at edge k+N are unchanged.
  - P is still cleared on reset.
- Undefined (default):
  - P changes only on reset (to 0) and at completion, as above.

Decomposition:
- Package booth_pkg:
  - Default width constant BOOTH_N = 8.
  - State enum type booth_state_t {LOAD, RUN, DONE}.
  - Booth-code localparams for the 2-bit selector values.
- One natural sub-module, booth_step:
  - Combinational block taking A, Qreg, Qm1 and Mreg.
  - Returns the add/sub/none result after the arithmetic right shift.
- The top module holds registers, counter and FSM.

Test Plan:
- m=125 (0x7D), q=38 (0x26): rst one cycle, wait 8 cycles -> P=0x128E (4750), stable on later cycles.
- m=-95 (0xA1), q=38 -> P=0xF1E6 (-3610) after 8 cycles. P reads 0 during the reset cycle.
- Corner operands:
  - m=-128 (0x80), q=-128 -> P=0x4000 (16384).
  - m=127, q=-128 -> P=0xC080 (-16256).
  - m=-1, q=-1 -> P=0x0001.
  - m=0, q=0x55 -> P=0.
- Reset mid-operation: start 125*38, assert rst at cycle 4 with m=-95, q=38 -> P=0xF1E6 exactly 8 cycles after release. The 4750 result never appears.
- Hold check: after completion keep rst=0 for 20 cycles and change m/q each cycle -> P unchanged.
- With BOOTH_LIVE_PRODUCT_EN defined, 125*38 -> P changes during RUN and equals 0x128E at edge k+8. Without the macro, P=0 until edge k+8.
